pixel_combinator: RTL and testbench
===================================

Name: pixel_combinator

Overview:
- Downstream consumer of the per-engine reorder queues. Walks the frame in raster order and broadcasts the next wanted coordinate on xpixel_check/ypixel_check to every queue.
- Collects the colour from whichever queue pops, then emits it on a ready/valid pixel stream with start-of-frame and end-of-line markers.
- Stops queues from popping while its output buffer is full.

Parameters:
- PIXEL_DATA_WIDTH, 10, width of the x and y coordinates.
- RBG_SIZE, 24, colour width.
- DATA_WIDTH, 32, output word width; colour is zero-extended into it.
- NUM_QUEUES, 4, number of upstream queues.
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start_i  in  1  one-cycle pulse that begins a frame; only honoured in IDLE.
- pop_i  in  NUM_QUEUES  bit q high for one cycle when queue q's registered colour output is valid for the current check coordinate.
- colour_i  in  NUM_QUEUES*RBG_SIZE  queue q's colour in slice q.
- xpixel_check  out  PIXEL_DATA_WIDTH  wanted x coordinate, broadcast to all queues.
- ypixel_check  out  PIXEL_DATA_WIDTH  wanted y coordinate, broadcast to all queues.
- out_data  out  DATA_WIDTH  pixel colour, zero-extended.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_sof  out  1  qualifies a pixel at (0,0).
- out_eol  out  1  qualifies a pixel with x == X_SIZE-1.
- busy  out  1  high outside IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel is consumed.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_sof=0, out_eol=0, busy=0, frame_done=0, err_o=0. Internal coordinate=(0,0), FIFO empty, state IDLE.
- Reset mid-frame: FIFO flushed, in-flight pixel dropped, return to IDLE.
- Never drive all-ones on the check ports; empty queue heads hold all-ones.
- State IDLE:
  - check = (X_SIZE-1, Y_SIZE-1), the parking coordinate.
  - On start_i: coordinate <= (0,0), go to SEEK.
- State SEEK:
  - check = current coordinate.
  - A queue matches at edge N; pop_i and colour_i are valid in cycle N+1.
  - At edge N+1:
    - Write {colour, sof, eol} into the output FIFO.
    - Advance the coordinate: x+1; at x == X_SIZE-1, x <= 0 and y+1.
  - If the written pixel was (X_SIZE-1, Y_SIZE-1): go to DRAIN.
  - Else if the FIFO is now full (2 entries): go to PARK.
- State PARK:
  - check = last consumed coordinate. It has already been popped and is unique per frame, so no queue can match.
  - Return to SEEK on the first edge where the FIFO count is below 2.
- State DRAIN:
  - check = parking coordinate.
  - When the FIFO empties: pulse frame_done for 1 cycle, go to IDLE.
- Pop selection:
  - If more than one pop_i bit is high, take the lowest index and set err_o.
  - A pop_i in IDLE, PARK or DRAIN is discarded and sets err_o.
- Output FIFO:
  - 2 entries, first-word-fall-through.
  - Latency is 1 cycle from pop_i to out_valid when the FIFO is empty.
  - A pixel transfers when out_valid && out_ready; simultaneous write and read is allowed at any occupancy.
  - out_data, out_sof and out_eol hold stable while out_valid && !out_ready.
- Width rules:
  - Coordinate counters are PIXEL_DATA_WIDTH wide.
  - Require X_SIZE and Y_SIZE < 2^PIXEL_DATA_WIDTH - 1; check with an elaboration assertion.
- start_i outside IDLE is ignored.

Decomposition:
- Package pixel_pkg holds:
  - width constants (PIXEL_DATA_WIDTH, RBG_SIZE, DATA_WIDTH);
  - typedef pixel_coord_t, a struct of x and y;
  - typedef out_beat_t, a struct of colour, sof and eol;
  - enum comb_state_t with IDLE, SEEK, PARK, DRAIN.
- One sub-module, pixel_out_fifo: 2-deep FWFT buffer of out_beat_t, exposing count, full and empty.
- The FSM, coordinate counters and pop mux stay in pixel_combinator.

Test Plan:
All scenarios use X_SIZE=4, Y_SIZE=2, NUM_QUEUES=4.
1. Basic frame:
   - Stimulus: start_i, out_ready=1; a queue model pops each check coordinate 1 cycle after it appears, rotating q0..q3, colour = 0x100*y + x.
   - Required: 8 beats, out_data 0x000,0x001,0x002,0x003,0x100,0x101,0x102,0x103; sof on beat 0 only; eol on beats 3 and 7; frame_done 1 cycle after the last beat is taken; busy drops with it.
2. Backpressure:
   - Stimulus: out_ready=0 from start.
   - Required: after 2 pops, state PARK and check holds (1,0) with no further pops; once out_ready=1, data order is intact and no beat is lost or duplicated.
3. Out-of-order engines:
   - Stimulus: the queue model delays (0,0) by 20 cycles while the other queues hold later coordinates.
   - Required: check stays (0,0) for the whole delay; output remains in raster order.
4. Protocol errors:
   - Stimulus: pop_i=4'b0110 in SEEK.
   - Required: colour taken from q1, err_o=1 and sticky.
   - Stimulus: pop_i pulse in IDLE.
   - Required: no beat emitted, err_o=1.
5. Mid-frame reset:
   - Stimulus: reset asserted after 3 beats with 1 beat pending in the FIFO.
   - Required: next cycle out_valid=0, busy=0, check=(3,1); start_i then restarts the frame from (0,0) with sof on its first beat.
6. Parking check:
   - Required: the check ports never equal 10'h3FF at any cycle across scenarios 1–5.

Source files
------------

// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared widths, coordinate/beat structs and FSM states for the pixel combinator
package pixel_pkg;

    localparam int PIXEL_DATA_WIDTH = 10;
    localparam int RBG_SIZE         = 24;
    localparam int DATA_WIDTH       = 32;

    typedef struct packed {
        logic [PIXEL_DATA_WIDTH-1:0] x;
        logic [PIXEL_DATA_WIDTH-1:0] y;
    } pixel_coord_t;

    typedef struct packed {
        logic [RBG_SIZE-1:0] colour;
        logic                sof;
        logic                eol;
    } out_beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        PARK  = 2'd2,
        DRAIN = 2'd3
    } comb_state_t;

endpackage

// File: rtl/pixel_combinator_if.sv
// rtl/pixel_combinator_if.sv - ready/valid pixel output stream
// Signals: out_data (zero-extended colour), out_valid, out_ready,
//          out_sof (pixel at (0,0)), out_eol (last pixel of a line).
// master = pixel source, slave = pixel sink.
interface pixel_combinator_if;
    import pixel_pkg::*;

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sof;
    logic                  out_eol;

    modport master (
        output out_data,
        output out_valid,
        output out_sof,
        output out_eol,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sof,
        input  out_eol,
        output out_ready
    );
endinterface

// File: rtl/pixel_out_fifo.sv
// rtl/pixel_out_fifo.sv - 2-entry first-word-fall-through buffer of output beats
// Ports: clk, reset (sync, active-high); wr_en/wr_data write side;
//        rd_en/rd_data read side (rd_data is the head while !empty);
//        count/full/empty occupancy status.
module pixel_out_fifo
    import pixel_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      wr_en,
    input  out_beat_t wr_data,
    input  logic      rd_en,
    output out_beat_t rd_data,
    output logic [1:0] count,
    output logic      full,
    output logic      empty
);
    out_beat_t mem [2];
    logic      wr_ptr;
    logic      rd_ptr;
    logic      wr_ok;
    logic      rd_ok;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign rd_ok   = rd_en && !empty;
    // A write into a full buffer is fine when the head leaves on the same edge.
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, wr_ok} - {1'b0, rd_ok};
        end
    end
endmodule

// File: rtl/pixel_combinator.sv
// rtl/pixel_combinator.sv - collects popped queue colours in raster order and streams them out
// Ports: clk, reset (sync, active-high); start_i frame start pulse (IDLE only);
//        pop_i/colour_i per-queue pop strobe and colour slice;
//        xpixel_check/ypixel_check wanted coordinate broadcast to all queues;
//        pix output pixel stream; busy (not IDLE); frame_done pulse; err_o sticky error.
module pixel_combinator
    import pixel_pkg::*;
#(
    parameter int X_SIZE     = 640,
    parameter int Y_SIZE     = 480,
    parameter int NUM_QUEUES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start_i,
    input  logic [NUM_QUEUES-1:0]          pop_i,
    input  logic [NUM_QUEUES*RBG_SIZE-1:0] colour_i,
    output logic [PIXEL_DATA_WIDTH-1:0]    xpixel_check,
    output logic [PIXEL_DATA_WIDTH-1:0]    ypixel_check,
    pixel_combinator_if.master             pix,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           err_o
);
    localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST = PIXEL_DATA_WIDTH'(X_SIZE - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST = PIXEL_DATA_WIDTH'(Y_SIZE - 1);
    localparam pixel_coord_t PARK_COORD = '{x: X_LAST, y: Y_LAST};

    // All-ones marks an empty queue head, so no real coordinate may reach it.
    if (X_SIZE >= (2 ** PIXEL_DATA_WIDTH) - 1 || Y_SIZE >= (2 ** PIXEL_DATA_WIDTH) - 1) begin : g_size_check
        $error("pixel_combinator: X_SIZE and Y_SIZE must be below 2**PIXEL_DATA_WIDTH - 1");
    end

    comb_state_t         state;
    comb_state_t         state_next;
    pixel_coord_t        coord;
    pixel_coord_t        last_coord;
    pixel_coord_t        check;
    logic [RBG_SIZE-1:0] sel_colour;
    logic                pop_any;
    logic                pop_multi;
    logic                pop_err;
    logic                is_last;
    logic                fifo_wr;
    logic                fifo_rd;
    logic [1:0]          fifo_count;
    logic [1:0]          count_next;
    logic                fifo_full;
    logic                fifo_empty;
    out_beat_t           wr_beat;
    out_beat_t           rd_beat;

    // Lowest-index pop wins: scan downwards so the last hit is the lowest bit.
    always_comb begin
        sel_colour = '0;
        for (int q = NUM_QUEUES - 1; q >= 0; q--) begin
            if (pop_i[q]) begin
                sel_colour = colour_i[q*RBG_SIZE +: RBG_SIZE];
            end
        end
    end

    assign pop_any   = |pop_i;
    assign pop_multi = |(pop_i & (pop_i - NUM_QUEUES'(1)));
    assign pop_err   = pop_any && ((state != SEEK) || pop_multi);
    assign is_last   = (coord.x == X_LAST) && (coord.y == Y_LAST);

    assign fifo_wr    = (state == SEEK) && pop_any;
    assign fifo_rd    = !fifo_empty && pix.out_ready;
    assign count_next = fifo_count + {1'b0, fifo_wr} - {1'b0, fifo_rd};

    assign wr_beat.colour = sel_colour;
    assign wr_beat.sof    = (coord.x == '0) && (coord.y == '0);
    assign wr_beat.eol    = (coord.x == X_LAST);

    pixel_out_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (wr_beat),
        .rd_en   (fifo_rd),
        .rd_data (rd_beat),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) state_next = SEEK;
            end
            SEEK: begin
                if (fifo_wr) begin
                    if (is_last) begin
                        state_next = DRAIN;
                    end else if (count_next == 2'd2) begin
                        state_next = PARK;
                    end
                end
            end
            PARK: begin
                if (!fifo_full) state_next = SEEK;
            end
            DRAIN: begin
                if (count_next == 2'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // While parked we show the pixel just taken: it is already popped and unique
    // within the frame, so no queue can match until we move on.
    always_comb begin
        busy  = (state != IDLE);
        check = PARK_COORD;
        case (state)
            SEEK:    check = coord;
            PARK:    check = last_coord;
            default: check = PARK_COORD;
        endcase
    end

    assign xpixel_check = check.x;
    assign ypixel_check = check.y;

    always_ff @(posedge clk) begin
        if (reset) begin
            coord      <= '0;
            last_coord <= '0;
            err_o      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == DRAIN) && (count_next == 2'd0);
            if (state == IDLE && start_i) begin
                coord <= '0;
            end else if (fifo_wr) begin
                last_coord <= coord;
                if (coord.x == X_LAST) begin
                    coord.x <= '0;
                    coord.y <= coord.y + 1'b1;
                end else begin
                    coord.x <= coord.x + 1'b1;
                end
            end
            if (pop_err) begin
                err_o <= 1'b1;
            end
        end
    end

    // Outputs are forced to zero while empty so stale buffer contents never show.
    assign pix.out_valid = !fifo_empty;
    assign pix.out_data  = fifo_empty ? '0 : DATA_WIDTH'(rd_beat.colour);
    assign pix.out_sof   = !fifo_empty && rd_beat.sof;
    assign pix.out_eol   = !fifo_empty && rd_beat.eol;
endmodule

// File: tb/tb_pixel_combinator.sv
// tb/tb_pixel_combinator.sv - directed self-checking bench for pixel_combinator
module tb_pixel_combinator;
    import pixel_pkg::*;

    localparam int XS = 4;
    localparam int YS = 2;
    localparam int NQ = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start_i;
    logic [NQ-1:0]           pop_i;
    logic [NQ*RBG_SIZE-1:0]  colour_i;
    logic [PIXEL_DATA_WIDTH-1:0] xpixel_check;
    logic [PIXEL_DATA_WIDTH-1:0] ypixel_check;
    logic                    busy;
    logic                    frame_done;
    logic                    err_o;

    logic                    man_sel;
    logic [NQ-1:0]           man_pop;
    logic [NQ*RBG_SIZE-1:0]  man_colour;
    logic [NQ-1:0]           model_pop = '0;
    logic [NQ*RBG_SIZE-1:0]  model_colour = '0;
    logic                    model_en;
    int                      hold_req;

    int checks   = 0;
    int failures = 0;

    pixel_combinator_if pix();

    assign pop_i    = man_sel ? man_pop : model_pop;
    assign colour_i = man_sel ? man_colour : model_colour;

    pixel_combinator #(
        .X_SIZE     (XS),
        .Y_SIZE     (YS),
        .NUM_QUEUES (NQ)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .pop_i        (pop_i),
        .colour_i     (colour_i),
        .xpixel_check (xpixel_check),
        .ypixel_check (ypixel_check),
        .pix          (pix),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    // Queue model: each coordinate lives in queue (index % NQ) with colour 0x100*y+x,
    // pops one cycle after its coordinate is seen, never pops the same pixel twice.
    logic [PIXEL_DATA_WIDTH-1:0] prev_x = '1;
    logic [PIXEL_DATA_WIDTH-1:0] prev_y = '1;
    logic prev_busy = 1'b0;
    bit   popped [8];
    int   hold_cnt = 0;
    int   m_idx = 0;

    always begin
        @(negedge clk);
        #1;
        model_pop    = '0;
        model_colour = '0;
        if (!model_en) begin
            for (int i = 0; i < 8; i++) popped[i] = 1'b0;
            hold_cnt  = hold_req;
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && int'(prev_x) < XS && int'(prev_y) < YS) begin
                m_idx = int'(prev_y) * XS + int'(prev_x);
                if (!popped[m_idx]) begin
                    if (m_idx == 0 && hold_cnt > 0) begin
                        hold_cnt = hold_cnt - 1;
                    end else begin
                        popped[m_idx] = 1'b1;
                        model_pop[m_idx % NQ] = 1'b1;
                        model_colour[(m_idx % NQ)*RBG_SIZE +: RBG_SIZE] =
                            RBG_SIZE'(256 * int'(prev_y) + int'(prev_x));
                    end
                end
            end
            prev_busy = busy;
        end
        prev_x = xpixel_check;
        prev_y = ypixel_check;
    end

    // Monitor: samples between edges, records transferred beats and events.
    logic [33:0] beats [$];
    int   cyc = 0;
    int   beat_cyc = 0;
    int   fd_cyc = 0;
    int   fd_cnt = 0;
    int   pop_cnt = 0;
    int   park_bad = 0;
    logic fd_busy = 1'b1;

    always begin
        @(negedge clk);
        #2;
        cyc = cyc + 1;
        if (pix.out_valid && pix.out_ready) begin
            beats.push_back({pix.out_data, pix.out_sof, pix.out_eol});
            beat_cyc = cyc;
        end
        if (frame_done) begin
            fd_cnt  = fd_cnt + 1;
            fd_cyc  = cyc;
            fd_busy = busy;
        end
        if (|pop_i) pop_cnt = pop_cnt + 1;
        if (xpixel_check == 10'h3FF || ypixel_check == 10'h3FF) park_bad = park_bad + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_frame_done(input string tag);
        int base;
        int n;
        base = fd_cnt;
        n = 0;
        while (fd_cnt == base && n < 300) begin
            @(negedge clk);
            n = n + 1;
        end
        check(tag, 64'(fd_cnt != base), 64'd1);
    endtask

    task automatic check_frame(input string tag, input int base);
        logic [33:0] v;
        logic [33:0] e;
        check({tag, "_count"}, 64'(beats.size() - base), 64'd8);
        for (int i = 0; i < 8; i++) begin
            v = (beats.size() > base + i) ? beats[base + i] : '1;
            e = {32'(256 * (i / 4) + i % 4), (i == 0), (i % 4 == 3)};
            check($sformatf("%s_beat%0d", tag, i), 64'(v), 64'(e));
        end
    endtask

    initial begin
        int base;
        int pbase;
        int fbase;
        int bad;
        int n;
        logic [33:0] v;

        reset = 1'b1;
        start_i = 1'b0;
        man_sel = 1'b0;
        man_pop = '0;
        man_colour = '0;
        model_en = 1'b0;
        hold_req = 0;
        pix.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_out_valid", 64'(pix.out_valid), 64'd0);
        check("rst_out_data", 64'(pix.out_data), 64'd0);
        check("rst_out_sof", 64'(pix.out_sof), 64'd0);
        check("rst_out_eol", 64'(pix.out_eol), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_check_x", 64'(xpixel_check), 64'd3);
        check("rst_check_y", 64'(ypixel_check), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        // 1. basic frame
        pix.out_ready = 1'b1;
        model_en = 1'b1;
        base = beats.size();
        fbase = fd_cnt;
        pulse_start();
        check("s1_busy", 64'(busy), 64'd1);
        check("s1_check_x0", 64'(xpixel_check), 64'd0);
        wait_frame_done("s1_done");
        check("s1_fd_latency", 64'(fd_cyc), 64'(beat_cyc + 1));
        check("s1_fd_busy", 64'(fd_busy), 64'd0);
        check_frame("s1", base);
        repeat (3) @(negedge clk);
        check("s1_fd_single", 64'(fd_cnt - fbase), 64'd1);
        check("s1_err", 64'(err_o), 64'd0);

        // 2. backpressure
        model_en = 1'b0;
        pix.out_ready = 1'b0;
        @(negedge clk);
        model_en = 1'b1;
        base = beats.size();
        pbase = pop_cnt;
        pulse_start();
        repeat (20) @(negedge clk);
        check("s2_pops", 64'(pop_cnt - pbase), 64'd2);
        check("s2_no_beats", 64'(beats.size() - base), 64'd0);
        check("s2_park_x", 64'(xpixel_check), 64'd1);
        check("s2_park_y", 64'(ypixel_check), 64'd0);
        check("s2_busy", 64'(busy), 64'd1);
        check("s2_head_valid", 64'(pix.out_valid), 64'd1);
        check("s2_head_sof", 64'(pix.out_sof), 64'd1);
        pix.out_ready = 1'b1;
        wait_frame_done("s2_done");
        check_frame("s2", base);

        // 3. out-of-order: (0,0) delayed
        model_en = 1'b0;
        hold_req = 20;
        @(negedge clk);
        model_en = 1'b1;
        hold_req = 0;
        base = beats.size();
        pulse_start();
        bad = 0;
        for (int i = 0; i < 18; i++) begin
            if (xpixel_check != 10'd0 || ypixel_check != 10'd0) bad = bad + 1;
            @(negedge clk);
        end
        check("s3_hold_check", 64'(bad), 64'd0);
        check("s3_hold_no_beats", 64'(beats.size() - base), 64'd0);
        wait_frame_done("s3_done");
        check_frame("s3", base);

        // 5. mid-frame reset with a beat pending
        model_en = 1'b0;
        @(negedge clk);
        model_en = 1'b1;
        base = beats.size();
        pulse_start();
        n = 0;
        while (beats.size() < base + 3 && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        pix.out_ready = 1'b0;
        check("s5_three_beats", 64'(beats.size() - base), 64'd3);
        n = 0;
        while (!pix.out_valid && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        check("s5_pending", 64'(pix.out_valid), 64'd1);
        reset = 1'b1;
        model_en = 1'b0;
        @(negedge clk);
        check("s5_valid", 64'(pix.out_valid), 64'd0);
        check("s5_busy", 64'(busy), 64'd0);
        check("s5_check_x", 64'(xpixel_check), 64'd3);
        check("s5_check_y", 64'(ypixel_check), 64'd1);
        reset = 1'b0;
        pix.out_ready = 1'b1;
        model_en = 1'b1;
        base = beats.size();
        pulse_start();
        wait_frame_done("s5_done");
        check_frame("s5", base);

        // 4. protocol errors
        reset = 1'b1;
        model_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("s4_err_clear", 64'(err_o), 64'd0);
        man_sel = 1'b1;
        base = beats.size();
        pulse_start();
        man_colour = {24'h333333, 24'h222222, 24'h111111, 24'hAAAAAA};
        man_pop = 4'b0110;
        @(negedge clk);
        man_pop = 4'b0000;
        repeat (3) @(negedge clk);
        check("s4_multi_count", 64'(beats.size() - base), 64'd1);
        v = (beats.size() > base) ? beats[base] : '1;
        check("s4_multi_beat", 64'(v), 64'({32'h0011_1111, 1'b1, 1'b0}));
        check("s4_multi_err", 64'(err_o), 64'd1);
        repeat (5) @(negedge clk);
        check("s4_err_sticky", 64'(err_o), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("s4_err_clear2", 64'(err_o), 64'd0);
        base = beats.size();
        man_pop = 4'b0001;
        @(negedge clk);
        man_pop = 4'b0000;
        repeat (3) @(negedge clk);
        check("s4_idle_no_beat", 64'(beats.size() - base), 64'd0);
        check("s4_idle_valid", 64'(pix.out_valid), 64'd0);
        check("s4_idle_busy", 64'(busy), 64'd0);
        check("s4_idle_err", 64'(err_o), 64'd1);
        man_sel = 1'b0;

        // 6. check ports never all-ones
        check("s6_no_all_ones", 64'(park_bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
